his_peak_finder: RTL and testbench

HIS_PEAK_FINDER -- requirements
Module: his_peak_finder

---
 rtl/his_peak_finder.sv | 159 +++++++++++++++
 tb/tb_his_peak_finder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/his_peak_finder.sv
// Streams each pixel's histogram out of RAM, tracks the peak bin and the bin sum, and emits one result per pixel.
// Optional PEAK_THRESH_EN adds min_count: peaks below it are reported as bin 0 / count 0.
module his_peak_finder #(
  parameter int BIN_W     = 6,
  parameter int BIN_NUM   = 64,
  parameter int PIX_W     = 8,
  parameter int PIXEL_NUM = 200,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  output logic                     his_rd_en,
  output logic [PIX_W+BIN_W-1:0]   his_rd_addr,
  input  logic [CNT_W-1:0]         his_rd_data,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic [PIX_W-1:0]         peak_pix,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [CNT_W-1:0]         peak_count,
  output logic [CNT_W+BIN_W-1:0]   total_count,
  output logic                     busy,
  output logic                     frame_done
`ifdef PEAK_THRESH_EN
  ,
  input  logic [CNT_W-1:0]         min_count
`endif
);

  localparam int SUM_W = CNT_W + BIN_W;
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BIN_NUM - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);

  typedef enum logic [2:0] {IDLE, READ, LAST, OUT, DONE} state_t;

  state_t             state;
  logic [PIX_W-1:0]   pix;
  logic [BIN_W-1:0]   bin;
  logic               rd_vld;
  logic [BIN_W-1:0]   rd_bin;
  logic [CNT_W-1:0]   run_max;
  logic [BIN_W-1:0]   run_bin;
  logic [SUM_W-1:0]   run_sum;

  logic [CNT_W-1:0]   nxt_max;
  logic [BIN_W-1:0]   nxt_bin;
  logic [SUM_W-1:0]   nxt_sum;
  logic [CNT_W-1:0]   rep_max;
  logic [BIN_W-1:0]   rep_bin;

  assign his_rd_addr = {pix, bin};

  // rd_vld/rd_bin track which bin the current his_rd_data belongs to (1-cycle RAM latency).
  always_comb begin
    nxt_max = run_max;
    nxt_bin = run_bin;
    nxt_sum = run_sum;
    if (rd_vld) begin
      if (rd_bin == '0) begin
        nxt_max = his_rd_data;
        nxt_bin = '0;
        nxt_sum = SUM_W'(his_rd_data);
      end else begin
        if (his_rd_data > run_max) begin
          nxt_max = his_rd_data;
          nxt_bin = rd_bin;
        end
        nxt_sum = run_sum + SUM_W'(his_rd_data);
      end
    end
  end

  always_comb begin
    rep_max = nxt_max;
    rep_bin = nxt_bin;
`ifdef PEAK_THRESH_EN
    if (nxt_max < min_count) begin
      rep_max = '0;
      rep_bin = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= IDLE;
      pix         <= '0;
      bin         <= '0;
      rd_vld      <= 1'b0;
      rd_bin      <= '0;
      run_max     <= '0;
      run_bin     <= '0;
      run_sum     <= '0;
      his_rd_en   <= 1'b0;
      peak_valid  <= 1'b0;
      peak_pix    <= '0;
      peak_bin    <= '0;
      peak_count  <= '0;
      total_count <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      rd_vld  <= his_rd_en;
      rd_bin  <= bin;
      run_max <= nxt_max;
      run_bin <= nxt_bin;
      run_sum <= nxt_sum;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            pix       <= '0;
            bin       <= '0;
            his_rd_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        READ: begin
          if (bin == BIN_LAST) begin
            his_rd_en <= 1'b0;
            state     <= LAST;
          end else begin
            bin <= bin + BIN_W'(1);
          end
        end
        LAST: begin
          // Final bin's datum arrives this cycle, so results come from the next-state values.
          state       <= OUT;
          peak_valid  <= 1'b1;
          peak_pix    <= pix;
          peak_bin    <= rep_bin;
          peak_count  <= rep_max;
          total_count <= nxt_sum;
        end
        OUT: begin
          if (peak_ready) begin
            peak_valid <= 1'b0;
            if (pix != PIX_LAST) begin
              pix       <= pix + PIX_W'(1);
              bin       <= '0;
              his_rd_en <= 1'b1;
              state     <= READ;
            end else begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_his_peak_finder.sv
// Directed bench for his_peak_finder with a 1-cycle-latency histogram RAM model; covers PEAK_THRESH_EN when defined.
module tb_his_peak_finder;

  localparam int BIN_W = 6;
  localparam int PIX_W = 8;
  localparam int CNT_W = 16;
  localparam int AW    = PIX_W + BIN_W;

  logic                   clk;
  logic                   res;
  logic                   start;
  logic                   his_rd_en;
  logic [AW-1:0]          his_rd_addr;
  logic [CNT_W-1:0]       his_rd_data;
  logic                   peak_valid;
  logic                   peak_ready;
  logic [PIX_W-1:0]       peak_pix;
  logic [BIN_W-1:0]       peak_bin;
  logic [CNT_W-1:0]       peak_count;
  logic [CNT_W+BIN_W-1:0] total_count;
  logic                   busy;
  logic                   frame_done;
`ifdef PEAK_THRESH_EN
  logic [CNT_W-1:0]       min_count;
`endif

  logic [CNT_W-1:0] mem [0:(1<<AW)-1];
  int vectors = 0;
  int errors  = 0;
  int cyc;

  his_peak_finder #(
    .BIN_W(BIN_W), .BIN_NUM(64), .PIX_W(PIX_W), .PIXEL_NUM(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .res(res), .start(start),
    .his_rd_en(his_rd_en), .his_rd_addr(his_rd_addr), .his_rd_data(his_rd_data),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pix(peak_pix),
    .peak_bin(peak_bin), .peak_count(peak_count), .total_count(total_count),
    .busy(busy), .frame_done(frame_done)
`ifdef PEAK_THRESH_EN
    , .min_count(min_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM returns data one cycle after the strobe; garbage otherwise.
  always @(posedge clk) his_rd_data <= his_rd_en ? mem[his_rd_addr] : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (peak_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    res = 1'b0;
    start = 1'b0;
    peak_ready = 1'b1;
    his_rd_data = '0;
`ifdef PEAK_THRESH_EN
    min_count = '0;
`endif
    clear_mem();
    tick();
    tick();
    chk("reset_outputs",
        {his_rd_en, his_rd_addr, peak_valid, peak_pix, peak_bin, peak_count, total_count, busy, frame_done}, '0);
    res = 1'b1;
    tick();

    // Scenario 1/6: pixel 0 bin 17 = 9, others 1; pixel 1 all zero
    for (int b = 0; b < 64; b++) mem[b] = 16'd1;
    mem[17] = 16'd9;
    start_frame();
    chk("first_read", {his_rd_en, his_rd_addr, busy}, {1'b1, 14'd0, 1'b1});
    wait_valid(cyc);
    chk("latency_65", cyc, 65);
    chk("p0_result", {peak_pix, peak_bin, peak_count, total_count}, {8'd0, 6'd17, 16'd9, 22'd72});
    chk("no_read_in_out", his_rd_en, 1'b0);
    wait_valid(cyc);
    chk("throughput_66", cyc, 66);
    chk("p1_zero", {peak_pix, peak_bin, peak_count, total_count}, {8'd1, 6'd0, 16'd0, 22'd0});
    tick();
    chk("done_pulse", {frame_done, busy, peak_valid}, 3'b110);
    tick();
    chk("back_idle", {frame_done, busy, his_rd_en}, 3'b000);

    // Scenarios 2/3/4: tie on bins 5/40, last-bin peak on pixel 1, backpressure, mid-frame start
    clear_mem();
    for (int b = 0; b < 64; b++) mem[b] = 16'd3;
    mem[5] = 16'd12;
    mem[40] = 16'd12;
    mem[64 + 63] = 16'd7;
    peak_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", {busy, his_rd_en, his_rd_addr}, {1'b1, 1'b1, 14'd6});
    wait_valid(cyc);
    chk("latency_after_restart", cyc, 59);
    chk("tie_low_bin", {peak_pix, peak_bin, peak_count, total_count}, {8'd0, 6'd5, 16'd12, 22'd210});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_stable", {peak_valid, his_rd_en, peak_pix, peak_bin, peak_count, total_count},
          {1'b1, 1'b0, 8'd0, 6'd5, 16'd12, 22'd210});
    end
    peak_ready = 1'b1;
    tick();
    chk("advance_after_ready", {peak_valid, his_rd_en, his_rd_addr}, {1'b0, 1'b1, 14'd64});
    wait_valid(cyc);
    chk("p1_latency", cyc, 65);
    chk("last_bin_peak", {peak_pix, peak_bin, peak_count, total_count}, {8'd1, 6'd63, 16'd7, 22'd7});
    tick();
    chk("done_pulse2", frame_done, 1'b1);
    tick();
    chk("idle2", {busy, frame_done}, 2'b00);

    // Scenario 4: asynchronous reset mid-READ, no resume afterwards
    start_frame();
    for (int i = 0; i < 20; i++) tick();
    chk("mid_read", {busy, his_rd_en}, 2'b11);
    res = 1'b0;
    #1;
    chk("async_reset",
        {his_rd_en, his_rd_addr, peak_valid, peak_pix, peak_bin, peak_count, total_count, busy, frame_done}, '0);
    #2;
    res = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("no_resume", {busy, his_rd_en, peak_valid}, 3'b000);

`ifdef PEAK_THRESH_EN
    // Scenario 5: min_count = 10; peak 9 suppressed, peak 10 reported
    clear_mem();
    mem[3] = 16'd9;
    mem[64 + 2] = 16'd10;
    min_count = 16'd10;
    start_frame();
    wait_valid(cyc);
    chk("thresh_below", {peak_bin, peak_count, total_count}, {6'd0, 16'd0, 22'd9});
    wait_valid(cyc);
    chk("thresh_equal", {peak_bin, peak_count, total_count}, {6'd2, 16'd10, 22'd10});
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
